// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS-subset control state machine
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       src_a,
    output logic [1:0] src_b,
    output logic       off,
    output logic       ls,
    output logic [2:0] alu_ctl,
    output logic       illegal,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    if (mem_ack) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:               state_d = S_EXEC_R;
                    6'h23, 6'h2B:        state_d = S_MEM_ADDR;
                    6'h04:               state_d = S_BRANCH;
                    6'h02:               state_d = S_JUMP;
                    6'h08, 6'h0C, 6'h0D: state_d = S_EXEC_I;
                    default:             state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ack) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ack) state_d = S_FETCH;
            S_EXEC_R: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: state_d = S_R_WB;
                    default:                           state_d = S_HALT;
                endcase
            end
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
        // Flag is raised on entry so it is already visible in the first HALT cycle
        if (state_d == S_HALT) illegal_d = 1'b1;
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        src_a      = 1'b0;
        src_b      = 2'b00;
        off        = 1'b0;
        ls         = 1'b0;
        alu_ctl    = 3'b000;
        illegal    = 1'b0;
        state_dbg  = 4'd0;
        if (!rst) begin
            state_dbg = state_q;
            illegal   = illegal_q;
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    src_b    = 2'b01;
                    alu_ctl  = ALU_ADD;
                    ir_write = mem_ack;
                    pc_write = mem_ack;
                end
                S_DECODE: begin
                    src_b   = 2'b10;
                    ls      = 1'b1;
                    alu_ctl = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    src_a   = 1'b1;
                    src_b   = 2'b10;
                    alu_ctl = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_EXEC_R: begin
                    src_a = 1'b1;
                    case (funct)
                        6'h20:   alu_ctl = ALU_ADD;
                        6'h22:   alu_ctl = ALU_SUB;
                        6'h24:   alu_ctl = ALU_AND;
                        6'h25:   alu_ctl = ALU_OR;
                        6'h2A:   alu_ctl = ALU_SLT;
                        default: alu_ctl = 3'b000;
                    endcase
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    src_a    = 1'b1;
                    alu_ctl  = ALU_SUB;
                    pc_src   = 2'b01;
                    pc_write = zero;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                S_EXEC_I: begin
                    src_a = 1'b1;
                    src_b = 2'b10;
                    case (opcode)
                        6'h0C:   begin alu_ctl = ALU_AND; off = 1'b1; end
                        6'h0D:   begin alu_ctl = ALU_OR;  off = 1'b1; end
                        default: alu_ctl = ALU_ADD;
                    endcase
                end
                S_I_WB:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - vector table plus cycle-count checks for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst, zero, mem_ack;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst;
    logic       mem_to_reg, src_a, off, ls, illegal;
    logic [1:0] pc_src, src_b;
    logic [2:0] alu_ctl;
    logic [3:0] state_dbg;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .src_a(src_a), .src_b(src_b), .off(off), .ls(ls), .alu_ctl(alu_ctl),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ack;
        logic [22:0] exp;
    } row_t;

    row_t        rows[$];
    logic [22:0] sb_q[$];
    int          total = 0;
    int          bad = 0;

    wire [22:0] dut_vec = {state_dbg, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                           reg_write, reg_dst, mem_to_reg, src_a, src_b, off, ls, alu_ctl, illegal};

    function automatic logic [22:0] ov(input logic [3:0] st, input logic req, we, io, irw, pcw,
                                       input logic [1:0] psrc, input logic rw, rd, m2r, sa,
                                       input logic [1:0] sb, input logic of, l,
                                       input logic [2:0] alu, input logic ill);
        return {st, req, we, io, irw, pcw, psrc, rw, rd, m2r, sa, sb, of, l, alu, ill};
    endfunction

    function automatic logic [22:0] e_fetch(input logic a);
        return ov(4'd0, 1, 0, 0, a, a, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 3'b010, 0);
    endfunction
    function automatic logic [22:0] e_dec();
        return ov(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 1, 3'b010, 0);
    endfunction
    function automatic logic [22:0] e_addr();
        return ov(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 0, 0, 3'b010, 0);
    endfunction
    function automatic logic [22:0] e_mrd();
        return ov(4'd3, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    endfunction
    function automatic logic [22:0] e_mwb();
        return ov(4'd4, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 0, 0, 3'b000, 0);
    endfunction
    function automatic logic [22:0] e_mwr();
        return ov(4'd5, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    endfunction
    function automatic logic [22:0] e_exr(input logic [2:0] alu);
        return ov(4'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, alu, 0);
    endfunction
    function automatic logic [22:0] e_rwb();
        return ov(4'd7, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    endfunction
    function automatic logic [22:0] e_br(input logic z);
        return ov(4'd8, 0, 0, 0, 0, z, 2'b01, 0, 0, 0, 1, 2'b00, 0, 0, 3'b110, 0);
    endfunction
    function automatic logic [22:0] e_j();
        return ov(4'd9, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    endfunction
    function automatic logic [22:0] e_exi(input logic [2:0] alu, input logic of);
        return ov(4'd10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, of, 0, alu, 0);
    endfunction
    function automatic logic [22:0] e_iwb();
        return ov(4'd11, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
    endfunction
    function automatic logic [22:0] e_halt();
        return ov(4'd15, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 1);
    endfunction

    task automatic add_row(input logic r, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ack, input logic [22:0] exp);
        rows.push_back('{r, op, fn, z, ack, exp});
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Runs one instruction from an idle FETCH; mem_ack is high only on cycles ack_a/ack_b
    task automatic measure(input logic [5:0] op, input int ack_a, input int ack_b, input logic z,
                           output int n, output int rd_n);
        bit seen = 0;
        bit done = 0;
        n = -1;
        rd_n = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            rst = 1'b0; opcode = op; funct = 6'h20; zero = z;
            mem_ack = (c == ack_a) || (c == ack_b);
            @(negedge clk);
            if (state_dbg == 4'd3) rd_n++;
            if (state_dbg != 4'd0) seen = 1;
            else if (seen) begin n = c; done = 1; end
        end
    endtask

    logic [22:0] got_v, exp_v;
    int n, rd_n;
    logic [5:0] rfn [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] ralu[4] = '{3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ack = 1'b0;

        add_row(1, 6'h00, 6'h00, 0, 0, 23'd0);
        add_row(1, 6'h00, 6'h00, 0, 1, 23'd0);
        add_row(0, 6'h00, 6'h20, 0, 1, e_fetch(1));
        add_row(0, 6'h00, 6'h20, 1, 0, e_dec());
        add_row(0, 6'h00, 6'h20, 0, 1, e_exr(3'b010));
        add_row(0, 6'h00, 6'h20, 0, 0, e_rwb());
        add_row(0, 6'h23, 6'h00, 0, 0, e_fetch(0));
        add_row(0, 6'h23, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h23, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h23, 6'h00, 0, 0, e_addr());
        add_row(0, 6'h23, 6'h00, 0, 0, e_mrd());
        add_row(0, 6'h23, 6'h00, 0, 0, e_mrd());
        add_row(0, 6'h23, 6'h00, 0, 1, e_mrd());
        add_row(0, 6'h23, 6'h00, 0, 1, e_mwb());
        add_row(0, 6'h2B, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h2B, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h2B, 6'h00, 0, 0, e_addr());
        add_row(0, 6'h2B, 6'h00, 0, 0, e_mwr());
        add_row(0, 6'h2B, 6'h00, 0, 1, e_mwr());
        add_row(0, 6'h04, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h04, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h04, 6'h00, 1, 0, e_br(1));
        add_row(0, 6'h04, 6'h00, 1, 1, e_fetch(1));
        add_row(0, 6'h04, 6'h00, 1, 0, e_dec());
        add_row(0, 6'h04, 6'h00, 0, 1, e_br(0));
        add_row(0, 6'h02, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h02, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h02, 6'h00, 0, 0, e_j());
        add_row(0, 6'h0D, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h0D, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h0D, 6'h00, 0, 0, e_exi(3'b001, 1));
        add_row(0, 6'h0D, 6'h00, 0, 0, e_iwb());
        add_row(0, 6'h0C, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h0C, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h0C, 6'h00, 0, 0, e_exi(3'b000, 1));
        add_row(0, 6'h0C, 6'h00, 0, 0, e_iwb());
        add_row(0, 6'h08, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h08, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h08, 6'h00, 0, 0, e_exi(3'b010, 0));
        add_row(0, 6'h08, 6'h00, 0, 0, e_iwb());
        for (int k = 0; k < 4; k++) begin
            add_row(0, 6'h00, rfn[k], 0, 1, e_fetch(1));
            add_row(0, 6'h00, rfn[k], 0, 0, e_dec());
            add_row(0, 6'h00, rfn[k], 0, 0, e_exr(ralu[k]));
            add_row(0, 6'h00, rfn[k], 0, 0, e_rwb());
        end
        add_row(0, 6'h00, 6'h3F, 0, 1, e_fetch(1));
        add_row(0, 6'h00, 6'h3F, 0, 0, e_dec());
        add_row(0, 6'h00, 6'h3F, 0, 0, e_exr(3'b000));
        add_row(0, 6'h00, 6'h3F, 0, 1, e_halt());
        add_row(0, 6'h00, 6'h3F, 1, 1, e_halt());
        add_row(1, 6'h00, 6'h3F, 1, 1, 23'd0);
        add_row(0, 6'h3F, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h3F, 6'h00, 0, 0, e_dec());
        for (int k = 0; k < 10; k++) add_row(0, 6'h3F, 6'h00, k[0], 1, e_halt());
        add_row(1, 6'h3F, 6'h00, 0, 0, 23'd0);
        add_row(0, 6'h23, 6'h00, 0, 1, e_fetch(1));
        add_row(0, 6'h23, 6'h00, 0, 0, e_dec());
        add_row(0, 6'h23, 6'h00, 0, 0, e_addr());
        add_row(0, 6'h23, 6'h00, 0, 0, e_mrd());
        add_row(1, 6'h23, 6'h00, 1, 1, 23'd0);
        add_row(0, 6'h23, 6'h00, 0, 0, e_fetch(0));

        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clk); #1;
            rst = rows[i].r; opcode = rows[i].op; funct = rows[i].fn;
            zero = rows[i].z; mem_ack = rows[i].ack;
            sb_q.push_back(rows[i].exp);
            @(negedge clk);
            got_v = dut_vec;
            exp_v = sb_q.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL vec[%0d] st=%0d got=%h exp=%h", i, state_dbg, got_v, exp_v);
            end
        end

        measure(6'h23, 0, 5, 1'b0, n, rd_n);
        check("lw_2wait_cycles", n, 7);
        check("lw_memrd_cycles", rd_n, 3);
        measure(6'h2B, 1, 4, 1'b0, n, rd_n);
        check("sw_fetchwait_cycles", n, 5);
        measure(6'h04, 0, -1, 1'b1, n, rd_n);
        check("beq_cycles", n, 3);
        measure(6'h00, 0, -1, 1'b0, n, rd_n);
        check("rtype_cycles", n, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control state machine for the MultiCPU datapath. It sequences fetch, decode, execute, memory and write-back for a MIPS subset. It drives the `alu_ctl`, `off` and `ls` controls consumed by `alu_wrapper`, plus the mux and write-enable controls for PC, IR, register file and memory. Memory accesses use a req/ack handshake, so wait states are supported.

## Interface
- No parameters; encodings are fixed below.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, registered by the datapath; valid in BRANCH.
- `mem_ack` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write, 0 = read; qualified by `mem_req`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR (and MDR) from memory data.
- `pc_write` out 1: load PC.
- `pc_src` out 2: PC source; 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 1: destination register; 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back data; 0 = ALUOut, 1 = MDR.
- `src_a` out 1: ALU A select; 0 = PC, 1 = rin_A.
- `src_b` out 2: ALU B select; 00 = rin_B, 01 = constant 4, 10 = offset.
- `off` out 1: offset extension; 0 = sign-extend, 1 = zero-extend.
- `ls` out 1: shift offset left by 2 (branch targets).
- `alu_ctl` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `illegal` out 1: sticky flag, set on an undecodable instruction.
- `state_dbg` out 4: current state code, for debug.

## Operation
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11, HALT 15.
- **FETCH**
  - Drives `mem_req`=1, `mem_we`=0, `iord`=0, `src_a`=0, `src_b`=01, `alu_ctl`=ADD, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only in the `mem_ack` cycle (Mealy).
  - Stays in FETCH until `mem_ack`, then goes to DECODE.
- **DECODE**
  - Computes the branch target: `src_a`=0, `src_b`=10, `off`=0, `ls`=1, ADD.
  - Next state by `opcode`:
    - 0x00 → EXEC_R.
    - 0x23 (lw) or 0x2B (sw) → MEM_ADDR.
    - 0x04 (beq) → BRANCH.
    - 0x02 (j) → JUMP.
    - 0x08 (addi), 0x0C (andi), 0x0D (ori) → EXEC_I.
    - Any other opcode → HALT.
- **MEM_ADDR**: `src_a`=1, `src_b`=10, `off`=0, `ls`=0, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: `mem_req`=1, `mem_we`=0, `iord`=1, `ir_write`=0. Holds until `mem_ack`, then MEM_WB.
- **MEM_WB**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- **MEM_WR**: `mem_req`=1, `mem_we`=1, `iord`=1. Holds until `mem_ack`, then FETCH.
- **EXEC_R**: `src_a`=1, `src_b`=00, `alu_ctl` from `funct`:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT → R_WB.
  - Any other funct → HALT, with no register write.
- **R_WB**: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- **BRANCH**: `src_a`=1, `src_b`=00, SUB, `pc_src`=01. `pc_write` = `zero`. → FETCH.
- **JUMP**: `pc_src`=10, `pc_write`=1 → FETCH.
- **EXEC_I**: `src_a`=1, `src_b`=10, `ls`=0.
  - addi: ADD, `off`=0.
  - andi: AND, `off`=1.
  - ori: OR, `off`=1.
  - → I_WB.
- **I_WB**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- **HALT**
  - `illegal`=1; all enables and `mem_req` are 0.
  - Remains in HALT until `rst`.
- **Defaults:** every output not listed for a state is 0.

## Timing
- `rst` high at a clock edge forces:
  - state to FETCH and `illegal` to 0;
  - all outputs to 0 while `rst` is high, which overrides the FETCH decode.
- The first FETCH request appears in the first cycle after `rst` falls.
- State register is updated on the rising edge. Outputs are combinational from state; the only input-dependent outputs are the FETCH write enables (`mem_ack`) and the BRANCH `pc_write` (`zero`).
- Cycle counts with a zero-wait memory (`mem_ack` in the first request cycle):
  - R-type, addi, andi, ori: 4.
  - lw: 5.
  - sw: 4.
  - beq, j: 3.
- Each memory wait cycle adds 1 cycle. During a wait, all outputs hold and there are no write enables.
- `mem_ack` outside MEM_RD, MEM_WR or FETCH is ignored.
- `rst` asserted mid-instruction (including during a wait) aborts it. No `reg_write` or `pc_write` is asserted in the reset cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release → `state_dbg`=0, `mem_req`=1 in the first cycle, `illegal`=0.
- **add:** opcode 0x00, funct 0x20, `mem_ack` tied high.
  - States 0→1→6→7→0.
  - `alu_ctl`=010 in EXEC_R.
  - `reg_write`=1 and `reg_dst`=1 only in cycle 4.
- **lw with 2 wait cycles:** opcode 0x23, `mem_ack` low 2 cycles in MEM_RD.
  - MEM_RD lasts 3 cycles with `iord`=1.
  - Total of 7 cycles.
  - `mem_to_reg`=1 in MEM_WB.
- **beq:** opcode 0x04.
  - With `zero`=1 → `pc_write`=1, `pc_src`=01 in BRANCH.
  - Repeated with `zero`=0 → `pc_write`=0, returns to FETCH.
- **ori:** opcode 0x0D → EXEC_I drives `alu_ctl`=001, `off`=1, `src_b`=10; I_WB drives `reg_dst`=0.
- **Illegal opcode then reset:** opcode 0x3F.
  - State becomes 15 with `illegal`=1.
  - No enables for 10 cycles.
  - Asserting `rst` clears `illegal` and restarts at FETCH.
